multicomp_core_sequencer: RTL and testbench

Sequencer that owns the selection, clocking and reset of the three MultiComp machine cores (Z80-CP/M, 6502-Basic, 6809-Basic). It sits between the OSD status/reset sources and the core instances. It debounces a requested machine change, drains the active core at a video frame boundary, and parks the old core in reset. It then moves the output mux select and releases the new core through a timed reset window. Only one core is ever clocked and out of reset at a time.

---
 rtl/multicomp_core_sequencer_if.sv | 21 ++
 rtl/multicomp_core_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_multicomp_core_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/multicomp_core_sequencer_if.sv
// Handshake bundle between the machine-select/reset sources and the core sequencer.
// The master side is the sequencer; the slave side is the OSD/core environment.
interface multicomp_core_sequencer_if;
    logic [1:0] sel_req;
    logic       rst_req;
    logic       vblank_in;
    logic [1:0] core_sel;
    logic [2:0] core_run;
    logic [2:0] core_nreset;
    logic       switching;

    modport master (
        input  sel_req, rst_req, vblank_in,
        output core_sel, core_run, core_nreset, switching
    );

    modport slave (
        output sel_req, rst_req, vblank_in,
        input  core_sel, core_run, core_nreset, switching
    );
endinterface

// File: rtl/multicomp_core_sequencer.sv
// Selects, clocks and resets one of three MultiComp cores, switching cleanly at a frame boundary.
// Optional macro MULTICOMP_SEQ_VBLANK_SYNC_EN: wait for a vblank rising edge (or timeout) before parking.
module multicomp_core_sequencer #(
    parameter int unsigned DEBOUNCE     = 1024,
    parameter int unsigned RESET_CYCLES = 64,
    parameter int unsigned VBL_TIMEOUT  = 1048576,
    parameter int unsigned CNT_W        = 20
) (
    input  logic                        clk,
    input  logic                        N_RESET,
    multicomp_core_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DEBNC   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_PARK    = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 32'd1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 32'd1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       cand_r, cand_s;
    logic [1:0]       sel_r, sel_s;
    logic [2:0]       run_r, run_s;
    logic [2:0]       nrst_r, nrst_s;
    logic             sw_r, sw_s;
    logic             drain_done_s;

    function automatic logic [2:0] core_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

`ifdef MULTICOMP_SEQ_VBLANK_SYNC_EN
    localparam logic [CNT_W-1:0] VBL_LAST = CNT_W'(VBL_TIMEOUT - 32'd1);
    logic vbl_d_r;

    // One-flop delay of vblank so only a fresh rising edge ends the drain.
    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            vbl_d_r <= 1'b0;
        end else begin
            vbl_d_r <= bus.vblank_in;
        end
    end

    assign drain_done_s = (bus.vblank_in & ~vbl_d_r) | (cnt_r == VBL_LAST);
`else
    logic unused_vbl_s;
    assign unused_vbl_s = bus.vblank_in ^ (VBL_TIMEOUT == 32'd0);
    assign drain_done_s = 1'b1;
`endif

    // Next state, shared cycle counter, switch candidate and committed core select.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 1'b1;
        cand_s  = cand_r;
        sel_s   = sel_r;
        case (state_r)
            ST_BOOT: begin
                if (bus.rst_req) begin
                    cnt_s = CNT_ZERO;
                end else if (cnt_r == RST_LAST) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_BOOT;
                end
            end
            ST_RUN: begin
                cnt_s = CNT_ZERO;
                if (bus.rst_req) begin
                    state_s = ST_BOOT;
                end else if ((bus.sel_req != sel_r) && (bus.sel_req != 2'd3)) begin
                    state_s = ST_DEBNC;
                    cand_s  = bus.sel_req;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DEBNC: begin
                if (bus.rst_req) begin
                    state_s = ST_BOOT;
                    cnt_s   = CNT_ZERO;
                end else if (bus.sel_req != cand_r) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = ST_DRAIN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_DEBNC;
                end
            end
            // User reset is deliberately ignored here: the switch always completes.
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_s = ST_PARK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_PARK: begin
                state_s = ST_RELEASE;
                cnt_s   = CNT_ZERO;
                sel_s   = cand_r;
            end
            ST_RELEASE: begin
                if (cnt_r == RST_LAST) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s = ST_BOOT;
                cnt_s   = CNT_ZERO;
                sel_s   = 2'd0;
            end
        endcase
    end

    // Output image of the state being entered, so registered outputs track the state register.
    always_comb begin
        run_s  = 3'b000;
        nrst_s = 3'b000;
        sw_s   = 1'b1;
        case (state_s)
            ST_BOOT, ST_RELEASE: begin
                run_s = core_onehot(sel_s);
            end
            ST_RUN: begin
                run_s  = core_onehot(sel_s);
                nrst_s = core_onehot(sel_s);
                sw_s   = 1'b0;
            end
            ST_DEBNC, ST_DRAIN: begin
                run_s  = core_onehot(sel_s);
                nrst_s = core_onehot(sel_s);
            end
            ST_PARK: begin
                run_s  = 3'b000;
                nrst_s = 3'b000;
            end
            default: begin
                run_s  = 3'b000;
                nrst_s = 3'b000;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge N_RESET) begin
        if (!N_RESET) begin
            state_r <= ST_BOOT;
            cnt_r   <= CNT_ZERO;
            cand_r  <= 2'd0;
            sel_r   <= 2'd0;
            run_r   <= 3'b000;
            nrst_r  <= 3'b000;
            sw_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cand_r  <= cand_s;
            sel_r   <= sel_s;
            run_r   <= run_s;
            nrst_r  <= nrst_s;
            sw_r    <= sw_s;
        end
    end

    assign bus.core_sel    = sel_r;
    assign bus.core_run    = run_r;
    assign bus.core_nreset = nrst_r;
    assign bus.switching   = sw_r;

endmodule

// File: tb/tb_multicomp_core_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes with their cycle numbers,
// a negedge monitor pops and compares every change of {core_sel, core_run, core_nreset, switching}.
module tb_multicomp_core_sequencer;

    localparam int TB_VBL_TIMEOUT = 3000;
`ifdef MULTICOMP_SEQ_VBLANK_SYNC_EN
    localparam bit VB_EN = 1'b1;
`else
    localparam bit VB_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [8:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [8:0] prev_v = {2'd0, 3'b000, 3'b000, 1'b1};

    multicomp_core_sequencer_if bus_if();

    multicomp_core_sequencer #(
        .DEBOUNCE(1024), .RESET_CYCLES(64), .VBL_TIMEOUT(TB_VBL_TIMEOUT), .CNT_W(20)
    ) dut (
        .clk(clk),
        .N_RESET(n_reset),
        .bus(bus_if)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] oh(input logic [1:0] s);
        logic [2:0] one;
        one = 3'b001;
        return one << s;
    endfunction

    task automatic push(input int c, input logic [1:0] s, input logic [2:0] r,
                        input logic [2:0] n, input logic w);
        exp_t e;
        e.cyc = c;
        e.val = {s, r, n, w};
        exp_q.push_back(e);
    endtask

    // Switch requested after edge e: DEBNC at e+1, DRAIN at e+1+1024, PARK after drain,
    // RELEASE one cycle later, RUN 64 cycles after that.
    task automatic push_switch(input int e, input logic [1:0] o, input logic [1:0] n, input int drain);
        int p;
        p = e + 1025 + drain;
        push(e + 1, o, oh(o), oh(o), 1'b1);
        push(p,     o, 3'b000, 3'b000, 1'b1);
        push(p + 1, n, oh(n), 3'b000, 1'b1);
        push(p + 65, n, oh(n), oh(n), 1'b0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output change must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [8:0] cur;
        exp_t       ev;
        cur = {bus_if.core_sel, bus_if.core_run, bus_if.core_nreset, bus_if.switching};
        if (cur !== prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b", cyc, cur, prev_v);
            end else begin
                ev = exp_q.pop_front();
                if ((ev.cyc != cyc) || (ev.val !== cur)) begin
                    errors++;
                    $display("FAIL output_event got cyc=%0d val=%b required cyc=%0d val=%b",
                             cyc, cur, ev.cyc, ev.val);
                end
            end
            checks++;
            if (($countones(bus_if.core_run) > 1) ||
                ((bus_if.core_nreset & ~oh(bus_if.core_sel)) != 3'b000)) begin
                errors++;
                $display("FAIL invariant cyc=%0d got run=%b nreset=%b sel=%0d required one-hot run, nreset only on sel",
                         cyc, bus_if.core_run, bus_if.core_nreset, bus_if.core_sel);
            end
            prev_v = cur;
        end
    end

    initial begin
        int e;
        int p;
        int r;
        int drain;
        n_reset          = 1'b0;
        bus_if.sel_req   = 2'd0;
        bus_if.rst_req   = 1'b0;
        bus_if.vblank_in = 1'b0;

        // Boot on core 0
        wait_until(5);
        n_reset = 1'b1;
        r = cyc;
        push(r + 1,  2'd0, 3'b001, 3'b000, 1'b1);
        push(r + 64, 2'd0, 3'b001, 3'b001, 1'b0);
        wait_until(r + 100);

        // Glitch reject: request core 1 for 1000 cycles only
        e = cyc;
        bus_if.sel_req = 2'd1;
        push(e + 1, 2'd0, 3'b001, 3'b001, 1'b1);
        wait_until(e + 1000);
        bus_if.sel_req = 2'd0;
        push(e + 1001, 2'd0, 3'b001, 3'b001, 1'b0);
        wait_until(e + 1100);

        // Invalid request: no output may move
        e = cyc;
        bus_if.sel_req = 2'd3;
        wait_until(e + 5000);
        bus_if.sel_req = 2'd0;
        wait_until(e + 5010);

        // User reset pulse of 10 cycles
        e = cyc;
        bus_if.rst_req = 1'b1;
        push(e + 1, 2'd0, 3'b001, 3'b000, 1'b1);
        wait_until(e + 10);
        bus_if.rst_req = 1'b0;
        push(e + 74, 2'd0, 3'b001, 3'b001, 1'b0);
        wait_until(e + 120);

        // Clean switch 0 -> 2, vblank rises 500 cycles after DRAIN entry
        e = cyc;
        bus_if.sel_req = 2'd2;
        drain = VB_EN ? 501 : 1;
        push_switch(e, 2'd0, 2'd2, drain);
        wait_until(e + 1525);
        bus_if.vblank_in = 1'b1;
        wait_until(e + 1540);
        bus_if.vblank_in = 1'b0;
        wait_until(e + 1700);

        // Switch 2 -> 1 with vblank already high at DRAIN entry; a later edge ends the drain
        e = cyc;
        bus_if.sel_req   = 2'd1;
        bus_if.vblank_in = 1'b1;
        drain = VB_EN ? 10 : 1;
        push_switch(e, 2'd2, 2'd1, drain);
        wait_until(e + 1030);
        bus_if.vblank_in = 1'b0;
        wait_until(e + 1034);
        bus_if.vblank_in = 1'b1;
        wait_until(e + 1050);
        bus_if.vblank_in = 1'b0;
        wait_until(e + 1200);

        // Timeout: vblank stuck low, switch 1 -> 0
        e = cyc;
        bus_if.sel_req = 2'd0;
        drain = VB_EN ? TB_VBL_TIMEOUT : 1;
        push_switch(e, 2'd1, 2'd0, drain);
        wait_until(e + 1025 + drain + 100);

        // Reset asserted during RELEASE toward core 1
        e = cyc;
        bus_if.sel_req = 2'd1;
        drain = VB_EN ? 20 : 1;
        p = e + 1025 + drain;
        push(e + 1, 2'd0, 3'b001, 3'b001, 1'b1);
        push(p,     2'd0, 3'b000, 3'b000, 1'b1);
        push(p + 1, 2'd1, 3'b010, 3'b000, 1'b1);
        wait_until(e + 1024 + drain);
        bus_if.vblank_in = 1'b1;
        wait_until(p + 10);
        n_reset = 1'b0;
        push(p + 10, 2'd0, 3'b000, 3'b000, 1'b1);
        wait_until(p + 13);
        n_reset = 1'b1;
        bus_if.vblank_in = 1'b0;
        r = cyc;
        push(r + 1,  2'd0, 3'b001, 3'b000, 1'b1);
        push(r + 64, 2'd0, 3'b001, 3'b001, 1'b0);
        push_switch(r + 64, 2'd0, 2'd1, drain);
        wait_until(r + 64 + 1024 + drain);
        bus_if.vblank_in = 1'b1;
        wait_until(r + 64 + 1025 + drain + 100);
        bus_if.vblank_in = 1'b0;
        wait_until(cyc + 5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d unseen, required 0 (next cyc=%0d val=%b)",
                     exp_q.size(), exp_q[0].cyc, exp_q[0].val);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
